// File: rtl/s2mm_burst_writer.sv
// s2mm_burst_writer: stream-to-memory AXI4 write engine.
// A command (start address, beat count) is split into INCR bursts of at most
// MAX_BURST beats that never cross a 4 KB page. Up to MAX_OUTSTANDING bursts may
// wait for their B response. W data passes straight through from the AXI4-Stream
// input and is gated so that no beat leaves before its AW has been accepted.
//
// Handshake rule on every channel: a transfer happens on a rising clock edge where
// valid and ready are both high. Once raised, a registered valid (awvalid) stays up
// with its payload unchanged until that transfer. wvalid/tready are combinational
// gates of the stream handshake and follow tvalid/wready.
module s2mm_burst_writer #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      m_axi_aclk,
  input  logic                      m_axi_aresetn,
  // command
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [LEN_WIDTH-1:0]      cmd_beats,
  // AW channel
  output logic [ADDR_WIDTH-1:0]     m_s2mm_axi_awaddr,
  output logic [7:0]                m_s2mm_axi_awlen,
  output logic [2:0]                m_s2mm_axi_awsize,
  output logic [1:0]                m_s2mm_axi_awburst,
  output logic [3:0]                m_s2mm_axi_awcache,
  output logic [2:0]                m_s2mm_axi_awprot,
  output logic                      m_s2mm_axi_awvalid,
  input  logic                      m_s2mm_axi_awready,
  // W channel
  output logic [DATA_WIDTH-1:0]     m_s2mm_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_s2mm_axi_wstrb,
  output logic                      m_s2mm_axi_wlast,
  output logic                      m_s2mm_axi_wvalid,
  input  logic                      m_s2mm_axi_wready,
  // B channel
  output logic                      m_s2mm_axi_bready,
  input  logic [1:0]                m_s2mm_axi_bresp,
  input  logic                      m_s2mm_axi_bvalid,
  // stream input
  input  logic [DATA_WIDTH-1:0]     s_s2mm_axis_tdata,
  input  logic                      s_s2mm_axis_tvalid,
  input  logic                      s_s2mm_axis_tlast,
  output logic                      s_s2mm_axis_tready,
  // status
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      tlast_err_o,
  output logic [1:0]                dbg_state_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Beats in the next burst: limited by what is left, MAX_BURST and the 4 KB page end.
  function automatic logic [8:0] burst_len(input logic [11:0] a, input logic [LEN_WIDTH-1:0] r);
    logic [31:0] room;
    logic [31:0] len;
    room = 32'(13'd4096 - {1'b0, a}) >> SIZE;
    len  = 32'(MAX_BURST);
    if (room < len) len = room;
    if (32'(r) < len) len = 32'(r);
    return 9'(len);
  endfunction

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [LEN_WIDTH-1:0]   total_q, total_d;
  logic [LEN_WIDTH-1:0]   cmd_beat_q, cmd_beat_d;
  logic                   awvalid_q, awvalid_d;
  logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
  logic [7:0]             awlen_q, awlen_d;
  logic [CNT_W-1:0]       ost_q, ost_d;
  logic [8:0]             fifo_mem_q [MAX_OUTSTANDING];
  logic [8:0]             fifo_mem_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [8:0]             beat_cnt_q, beat_cnt_d;
  logic                   err_q, err_d;
  logic                   tlast_err_q, tlast_err_d;

  logic                   aw_hs;
  logic                   w_hs;
  logic                   b_hs;
  logic                   fifo_ne;
  logic [8:0]             fifo_head;
  logic                   w_last;
  logic                   w_pop;
  logic [8:0]             cur_len;
  logic [8:0]             push_len;
  logic                   final_beat;

  // Handshake decodes and W-channel gating derived from the burst FIFO head.
  always_comb begin
    aw_hs      = awvalid_q & m_s2mm_axi_awready;
    fifo_ne    = (fifo_cnt_q != '0);
    fifo_head  = fifo_mem_q[rd_ptr_q];
    w_last     = fifo_ne && (beat_cnt_q == (fifo_head - 9'd1));
    w_hs       = s_s2mm_axis_tvalid & fifo_ne & m_s2mm_axi_wready;
    w_pop      = w_hs & w_last;
    b_hs       = m_s2mm_axi_bvalid && (ost_q != '0);
    cur_len    = burst_len(addr_q[11:0], rem_q);
    push_len   = {1'b0, awlen_q} + 9'd1;
    final_beat = (cmd_beat_q == (total_q - LEN_WIDTH'(1)));
  end

  // Next-state: FSM, address/remaining walk, AW issue, FIFO, counters, sticky flags.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    total_d     = total_q;
    cmd_beat_d  = cmd_beat_q;
    awvalid_d   = awvalid_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    ost_d       = ost_q;
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    tlast_err_d = tlast_err_q;

    // Accepted burst: advance the walk and remember its length for the W side.
    if (aw_hs) begin
      addr_d    = addr_q + (ADDR_WIDTH'(cur_len) << SIZE);
      rem_d     = rem_q - LEN_WIDTH'(cur_len);
      awvalid_d = 1'b0;
      fifo_mem_d[wr_ptr_q] = push_len;
      wr_ptr_d  = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    // Outstanding bursts waiting for B.
    case ({aw_hs, b_hs})
      2'b10:   ost_d = ost_q + CNT_W'(1);
      2'b01:   ost_d = ost_q - CNT_W'(1);
      default: ost_d = ost_q;
    endcase

    // W beat accounting; the final beat of a burst releases its FIFO entry.
    if (w_hs) begin
      beat_cnt_d = w_last ? 9'd0 : beat_cnt_q + 9'd1;
      cmd_beat_d = cmd_beat_q + LEN_WIDTH'(1);
      if (s_s2mm_axis_tlast != final_beat) tlast_err_d = 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    fifo_cnt_d = fifo_cnt_q + CNT_W'(aw_hs) - CNT_W'(w_pop);

    if (b_hs && (m_s2mm_axi_bresp != 2'b00)) err_d = 1'b1;

    // Raise awvalid for the next burst, back-to-back with a handshake when possible.
    if ((state_q == S_ISSUE) && (!awvalid_q || aw_hs) && (rem_d != '0) &&
        (ost_d < CNT_W'(MAX_OUTSTANDING)) && (fifo_cnt_d < CNT_W'(MAX_OUTSTANDING))) begin
      awvalid_d = 1'b1;
      awaddr_d  = addr_d;
      awlen_d   = 8'(burst_len(addr_d[11:0], rem_d) - 9'd1);
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
          rem_d       = cmd_beats;
          total_d     = cmd_beats;
          cmd_beat_d  = '0;
          err_d       = 1'b0;
          tlast_err_d = 1'b0;
          state_d     = (cmd_beats == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (aw_hs && (rem_d == '0)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((fifo_cnt_q == '0) && (ost_q == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; asynchronous reset abandons any command in flight.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      total_q     <= '0;
      cmd_beat_q  <= '0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      ost_q       <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      tlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      total_q     <= total_d;
      cmd_beat_q  <= cmd_beat_d;
      awvalid_q   <= awvalid_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      ost_q       <= ost_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      tlast_err_q <= tlast_err_d;
    end
  end

  assign cmd_ready          = (state_q == S_IDLE);
  assign m_s2mm_axi_awaddr  = awaddr_q;
  assign m_s2mm_axi_awlen   = awlen_q;
  assign m_s2mm_axi_awsize  = 3'(SIZE);
  assign m_s2mm_axi_awburst = 2'b01;
  assign m_s2mm_axi_awcache = 4'b0011;
  assign m_s2mm_axi_awprot  = 3'b000;
  assign m_s2mm_axi_awvalid = awvalid_q;
  assign m_s2mm_axi_wdata   = s_s2mm_axis_tdata;
  assign m_s2mm_axi_wstrb   = '1;
  assign m_s2mm_axi_wlast   = w_last;
  assign m_s2mm_axi_wvalid  = s_s2mm_axis_tvalid & fifo_ne;
  assign s_s2mm_axis_tready = m_s2mm_axi_wready & fifo_ne;
  assign m_s2mm_axi_bready  = 1'b1;
  assign busy_o             = (state_q != S_IDLE);
  assign done_o             = (state_q == S_DONE);
  assign err_o              = err_q;
  assign tlast_err_o        = tlast_err_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_s2mm_burst_writer.sv
// Testbench for s2mm_burst_writer: directed commands, a stream driver, a B responder
// and a monitor that pops expected AW/W transfers from queues as the DUT presents them.
module tb_s2mm_burst_writer;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int LW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_beats;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic [3:0]    awcache;
  logic [2:0]    awprot;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wlast, wvalid, wready;
  logic          bready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tready;
  logic          busy_o, done_o, err_o, tlast_err_o;
  logic [1:0]    dbg_state;

  s2mm_burst_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_BURST(16), .MAX_OUTSTANDING(4)
  ) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .m_s2mm_axi_awaddr(awaddr), .m_s2mm_axi_awlen(awlen), .m_s2mm_axi_awsize(awsize),
    .m_s2mm_axi_awburst(awburst), .m_s2mm_axi_awcache(awcache), .m_s2mm_axi_awprot(awprot),
    .m_s2mm_axi_awvalid(awvalid), .m_s2mm_axi_awready(awready),
    .m_s2mm_axi_wdata(wdata), .m_s2mm_axi_wstrb(wstrb), .m_s2mm_axi_wlast(wlast),
    .m_s2mm_axi_wvalid(wvalid), .m_s2mm_axi_wready(wready),
    .m_s2mm_axi_bready(bready), .m_s2mm_axi_bresp(bresp), .m_s2mm_axi_bvalid(bvalid),
    .s_s2mm_axis_tdata(tdata), .s_s2mm_axis_tvalid(tvalid), .s_s2mm_axis_tlast(tlast),
    .s_s2mm_axis_tready(tready),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .tlast_err_o(tlast_err_o),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+7:0] exp_aw_q[$];   // {awaddr, awlen}
  logic [DW:0]   exp_w_q[$];    // {wlast, wdata}
  int            burst_len_q[$];

  int aw_cnt = 0, wlast_cnt = 0, b_seen = 0, b_sent = 0, done_cnt = 0, b_at_done = 0;
  bit b_hold = 1'b0;
  int b_err_at = 0;
  bit stream_busy = 1'b0;
  bit err_m = 1'b0, tlast_err_m = 1'b0;
  int cmd_total_m = 0, w_idx_m = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [AW+7:0] ea;
    logic [DW:0]   ew;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        err_m = 1'b0;
        tlast_err_m = 1'b0;
      end else begin
        check("err_o", err_o, err_m);
        check("tlast_err_o", tlast_err_o, tlast_err_m);
        if (cmd_valid && cmd_ready) begin
          err_m = 1'b0;
          tlast_err_m = 1'b0;
          cmd_total_m = int'(cmd_beats);
          w_idx_m = 0;
        end
        if (awvalid && awready) begin
          aw_cnt++;
          if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
          else begin
            ea = exp_aw_q.pop_front();
            check("awaddr", awaddr, ea[AW+7:8]);
            check("awlen", awlen, ea[7:0]);
            check("awsize", awsize, 3'd3);
            check("awburst", awburst, 2'b01);
            check("awcache", awcache, 4'b0011);
            check("awprot", awprot, 3'b000);
          end
        end
        if (wvalid && wready) begin
          if (exp_w_q.size() == 0) fail_now("w_unexpected");
          else begin
            ew = exp_w_q.pop_front();
            check("wdata", wdata, ew[DW-1:0]);
            check("wlast", wlast, ew[DW]);
            check("wstrb", wstrb, 8'hFF);
          end
          if (tlast != (w_idx_m == cmd_total_m - 1)) tlast_err_m = 1'b1;
          w_idx_m++;
          if (wlast) wlast_cnt++;
        end
        if (bvalid && bready) begin
          b_seen++;
          if (bresp != 2'b00) err_m = 1'b1;
        end
        if (done_o) begin
          done_cnt++;
          b_at_done = b_seen;
        end
      end
    end
  end

  // ---------------- B responder: one response per completed burst ----------------
  initial begin
    bvalid = 1'b0;
    bresp  = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && !b_hold && (wlast_cnt > b_sent)) begin
        bvalid = 1'b1;
        bresp  = (b_sent + 1 == b_err_at) ? 2'b10 : 2'b00;
        b_sent++;
      end else begin
        bvalid = 1'b0;
        bresp  = 2'b00;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_aw(input logic [AW-1:0] a, input int len);
    exp_aw_q.push_back({a, 8'(len - 1)});
    burst_len_q.push_back(len);
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] n);
    int to = 0;
    cmd_addr = a;
    cmd_beats = n;
    cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      to++;
    end while (!cmd_ready && to < 1000);
    if (!cmd_ready) fail_now("cmd_accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // tlast_at is the 1-based beat carrying tlast (0 = none).
  task automatic stream_beats(input int n, input int tlast_at);
    int in_burst = 0;
    int cur_len = 0;
    int to;
    logic [DW-1:0] d;
    bit last;
    stream_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (in_burst == 0) cur_len = (burst_len_q.size() > 0) ? burst_len_q.pop_front() : 0;
      d = {32'hC0DE_0000 + 32'(i) + 32'(n << 8), 32'(i) ^ 32'h5A5A_5A5A};
      last = (in_burst == cur_len - 1);
      exp_w_q.push_back({last, d});
      tdata  = d;
      tvalid = 1'b1;
      tlast  = (i + 1 == tlast_at);
      to = 0;
      do begin
        @(negedge clk);
        to++;
      end while (!tready && to < 3000);
      if (!tready) begin
        fail_now("w_beat_timeout");
        break;
      end
      @(posedge clk);
      #1;
      in_burst = last ? 0 : in_burst + 1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    stream_busy = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int to = 0;
    while (done_cnt == d0 && to < 3000) begin
      @(posedge clk);
      to++;
    end
    if (done_cnt == d0) fail_now("done_timeout");
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, a0, w0, b0, to;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    awready = 1'b1; wready = 1'b1;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_bready", bready, 1'b1);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_wlast", wlast, 1'b0);
    check("rst_tready", tready, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_tlast_err", tlast_err_o, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 40 beats at 0x1000: 16 + 16 + 8
    d0 = done_cnt; w0 = wlast_cnt;
    expect_aw(32'h1000, 16); expect_aw(32'h1080, 16); expect_aw(32'h1100, 8);
    send_cmd(32'h1000, 16'd40);
    check("busy_after_accept", busy_o, 1'b1);
    stream_beats(40, 40);
    wait_done(d0);
    check("t1_wlast_count", 64'(wlast_cnt - w0), 64'd3);
    check("t1_err", err_o, 1'b0);

    // SLVERR on the second of three bursts
    d0 = done_cnt;
    b_err_at = b_sent + 2;
    expect_aw(32'h3000, 16); expect_aw(32'h3080, 16); expect_aw(32'h3100, 8);
    send_cmd(32'h3004, 16'd40);  // low address bits are dropped
    stream_beats(40, 40);
    wait_done(d0);
    check("t4_err_sticky", err_o, 1'b1);

    // 8 beats with tlast on beat 5; clears err_o on accept
    d0 = done_cnt; w0 = wlast_cnt;
    expect_aw(32'h4000, 8);
    send_cmd(32'h4000, 16'd8);
    stream_beats(8, 5);
    wait_done(d0);
    check("t5_tlast_err", tlast_err_o, 1'b1);
    check("t5_err_cleared", err_o, 1'b0);
    check("t5_wlast_count", 64'(wlast_cnt - w0), 64'd1);

    // zero-beat command: done one cycle after accept, no traffic
    d0 = done_cnt; a0 = aw_cnt;
    send_cmd(32'h4100, 16'd0);
    check("t5b_done_next", done_o, 1'b1);
    @(posedge clk);
    #1;
    check("t5b_done_one_cycle", done_o, 1'b0);
    check("t5b_idle", busy_o, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t5b_no_aw", 64'(aw_cnt - a0), 64'd0);
    check("t5b_done_count", 64'(done_cnt - d0), 64'd1);
    check("t5b_tlast_err_cleared", tlast_err_o, 1'b0);

    // outstanding limit: 6 bursts, B withheld
    d0 = done_cnt; a0 = aw_cnt; b0 = b_seen;
    b_hold = 1'b1;
    for (int i = 0; i < 6; i++) expect_aw(32'h5000 + 32'(i * 128), 16);
    send_cmd(32'h5000, 16'd96);
    fork
      stream_beats(96, 96);
    join_none
    repeat (150) @(posedge clk);
    #1;
    check("t3_aw_limit", 64'(aw_cnt - a0), 64'd4);
    check("t3_awvalid_low", awvalid, 1'b0);
    check("t3_no_done", 64'(done_cnt - d0), 64'd0);
    b_hold = 1'b0;
    to = 0;
    while (stream_busy && to < 3000) begin
      @(posedge clk);
      to++;
    end
    if (stream_busy) fail_now("t3_stream_timeout");
    wait_done(d0);
    check("t3_b_before_done", 64'(b_at_done - b0), 64'd6);
    check("t3_aw_total", 64'(aw_cnt - a0), 64'd6);

    // asynchronous reset mid-burst
    awready = 1'b0;
    b_hold = 1'b1;
    expect_aw(32'h2000, 16);
    send_cmd(32'h2000, 16'd32);
    to = 0;
    do begin
      @(negedge clk);
      to++;
    end while (!awvalid && to < 100);
    @(posedge clk);
    #1;
    awready = 1'b1;
    @(posedge clk);
    #1;
    awready = 1'b0;
    stream_beats(5, 0);
    wready = 1'b0;
    tdata  = 64'hDEAD_BEEF_0000_0006;
    tvalid = 1'b1;
    @(negedge clk);
    check("t6_awvalid_before", awvalid, 1'b1);
    check("t6_wvalid_before", wvalid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_awvalid_rst", awvalid, 1'b0);
    check("t6_wvalid_rst", wvalid, 1'b0);
    check("t6_busy_rst", busy_o, 1'b0);
    check("t6_cmd_ready_rst", cmd_ready, 1'b1);
    check("t6_state_rst", dbg_state, 2'd0);
    tvalid = 1'b0;
    wready = 1'b1;
    awready = 1'b1;
    burst_len_q.delete();
    exp_aw_q.delete();
    b_hold = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // after reset: 4 beats at 0x0FF0 split at the 4 KB page
    d0 = done_cnt; w0 = wlast_cnt;
    expect_aw(32'h0FF0, 2); expect_aw(32'h1000, 2);
    send_cmd(32'h0FF0, 16'd4);
    stream_beats(4, 4);
    wait_done(d0);
    check("t2_wlast_count", 64'(wlast_cnt - w0), 64'd2);

    check("aw_queue_empty", 64'(exp_aw_q.size()), 64'd0);
    check("w_queue_empty", 64'(exp_w_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
